// File: rtl/nn_pkg.sv
// Shared types and constants for the fully-connected layer MAC engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nn_pkg;

    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_W_ADDR_W  = 16;
    localparam int DEF_ACC_W     = 40;
    localparam int DEF_FRAC_BITS = 0;

    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        BIAS,
        SUM,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/nn_act_sat.sv
// Fixed-point rescale, optional ReLU and saturation of the accumulator to neuron width.
// Latency: combinational.
// Backpressure: none.
module nn_act_sat
    import nn_pkg::*;
#(
    parameter int ACC_W     = DEF_ACC_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic                     relu_en,
    output logic        [DATA_W-1:0] res
);

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(SAT_MIN);

    logic signed [ACC_W-1:0] shifted;

    assign shifted = acc >>> FRAC_BITS;

    // ReLU runs before saturation so a clamped negative never reaches SAT_MIN
    always_comb begin
        res = shifted[DATA_W-1:0];
        if (relu_en && (shifted < 0))
            res = '0;
        else if (shifted > MAX_V)
            res = DATA_W'(SAT_MAX);
        else if (shifted < MIN_V)
            res = DATA_W'(SAT_MIN);
    end

endmodule

// File: rtl/layer_mac_engine.sv
// Computes one fully-connected layer: in_count MACs + bias per output, ReLU, saturate, write back.
// Latency: out_count*(in_count+3) cycles from start to final write, done one cycle later.
// Backpressure: none; memories are fixed 1-cycle latency, start is ignored while running.
module layer_mac_engine
    import nn_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int W_ADDR_W  = DEF_W_ADDR_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   in_base,
    input  logic [ADDR_W-1:0]   in_count,
    input  logic [ADDR_W-1:0]   out_base,
    input  logic [ADDR_W-1:0]   out_count,
    input  logic [W_ADDR_W-1:0] w_base,
    input  logic                relu_en,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   rd_data,
    output logic [W_ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0]   w_data,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data
);

    state_t                  state;
    logic [ADDR_W-1:0]       in_base_q, in_count_q, out_base_q, out_count_q;
    logic                    relu_q;
    logic [ADDR_W-1:0]       i_cnt, j_cnt;
    logic                    mac_vld;
    logic signed [ACC_W-1:0] acc;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext, bias_ext, acc_sum;
    logic        [DATA_W-1:0]   act_res;

    assign prod     = $signed(rd_data) * $signed(w_data);
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_W){w_data[DATA_W-1]}}, w_data} <<< FRAC_BITS;
    assign acc_sum  = acc + bias_ext;

    nn_act_sat #(
        .ACC_W     (ACC_W),
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_act_sat (
        .acc     (acc_sum),
        .relu_en (relu_q),
        .res     (act_res)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_en       <= 1'b0;
            rd_addr     <= '0;
            w_addr      <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            acc         <= '0;
            mac_vld     <= 1'b0;
            in_base_q   <= '0;
            in_count_q  <= '0;
            out_base_q  <= '0;
            out_count_q <= '0;
            relu_q      <= 1'b0;
            i_cnt       <= '0;
            j_cnt       <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            // read data lands one cycle after its address, so the MAC trails READ by a cycle
            mac_vld <= (state == READ);
            if (mac_vld)
                acc <= acc + prod_ext;

            case (state)
                IDLE: begin
                    if (start) begin
                        in_base_q   <= in_base;
                        in_count_q  <= in_count;
                        out_base_q  <= out_base;
                        out_count_q <= out_count;
                        relu_q      <= relu_en;
                        rd_addr     <= in_base;
                        w_addr      <= w_base;
                        i_cnt       <= '0;
                        j_cnt       <= '0;
                        acc         <= '0;
                        if ((in_count == '0) || (out_count == '0)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                            busy  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    rd_addr <= rd_addr + 1'b1;
                    w_addr  <= w_addr + 1'b1;
                    i_cnt   <= i_cnt + 1'b1;
                    if (i_cnt == in_count_q - 1'b1)
                        state <= BIAS;
                end
                BIAS: begin
                    w_addr <= w_addr + 1'b1;
                    state  <= SUM;
                end
                SUM: begin
                    acc     <= acc_sum;
                    wr_data <= act_res;
                    wr_addr <= out_base_q + j_cnt;
                    wr_en   <= 1'b1;
                    state   <= WRITE;
                end
                WRITE: begin
                    acc     <= '0;
                    i_cnt   <= '0;
                    rd_addr <= in_base_q;
                    if (ADDR_W'(j_cnt + 1'b1) < out_count_q) begin
                        j_cnt <= j_cnt + 1'b1;
                        state <= READ;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_mac_engine.sv
// Directed bench for layer_mac_engine with behavioural neuron memory and weight ROM.
module tb_layer_mac_engine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [11:0] in_base, in_count, out_base, out_count;
    logic [15:0] w_base;
    logic        relu_en;
    logic        busy, done;
    logic [11:0] rd_addr;
    logic [15:0] rd_data;
    logic [15:0] w_addr;
    logic [15:0] w_data;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;

    logic [15:0] nmem [4096];
    logic [15:0] wrom [65536];

    int n_vec = 0;
    int n_err = 0;

    int cyc, done_cyc, busy_first, busy_hi, busy_at_done, wr_n;
    int wr_a [8];
    int wr_d [8];
    int wr_c [8];

    layer_mac_engine dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .in_base   (in_base),
        .in_count  (in_count),
        .out_base  (out_base),
        .out_count (out_count),
        .w_base    (w_base),
        .relu_en   (relu_en),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data <= nmem[rd_addr];
        w_data  <= wrom[w_addr];
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_rom();
        for (int k = 0; k < 65536; k++) wrom[k] = 16'h0;
    endtask

    // per-neuron layout: n weights of value wv then one bias of bias0+j
    task automatic load_w(input int base, input int n, input int outs, input int wv, input int bias0);
        clear_rom();
        for (int j = 0; j < outs; j++) begin
            for (int i = 0; i < n; i++) wrom[(base + j*(n+1) + i) % 65536] = 16'(wv);
            wrom[(base + j*(n+1) + n) % 65536] = 16'(bias0 + j);
        end
    endtask

    task automatic run(input int ib, input int ic, input int ob, input int oc,
                       input int wb, input bit relu, input bit second_start);
        repeat (2) @(negedge clk);
        in_base   = 12'(ib);
        in_count  = 12'(ic);
        out_base  = 12'(ob);
        out_count = 12'(oc);
        w_base    = 16'(wb);
        relu_en   = relu;
        start     = 1'b1;
        done_cyc = -1; busy_hi = 0; busy_first = 0; busy_at_done = -1; wr_n = 0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        busy_first = int'(busy);
        while (cyc <= 300) begin
            if (busy) busy_hi = 1;
            if (wr_en && wr_n < 8) begin
                wr_a[wr_n] = int'(wr_addr);
                wr_d[wr_n] = int'($signed(wr_data));
                wr_c[wr_n] = cyc;
                wr_n++;
            end
            if (done) begin
                done_cyc = cyc;
                busy_at_done = int'(busy);
                break;
            end
            if (second_start && cyc == 3) begin
                start     = 1'b1;
                in_base   = 12'd0;
                out_base  = 12'd500;
                out_count = 12'd1;
                w_base    = 16'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    initial begin
        int rst_wr;
        for (int k = 0; k < 4096; k++) nmem[k] = 16'h0;
        for (int k = 0; k < 8; k++)  nmem[k] = 16'd4;
        for (int k = 8; k < 16; k++) nmem[k] = 16'hFFFD;
        clear_rom();
        reset_n = 1'b0; start = 1'b0; relu_en = 1'b0;
        in_base = '0; in_count = '0; out_base = '0; out_count = '0; w_base = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",    int'(busy),    0);
        check("rst_done",    int'(done),    0);
        check("rst_wr_en",   int'(wr_en),   0);
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_w_addr",  int'(w_addr),  0);
        check("rst_wr_data", int'(wr_data), 0);
        reset_n = 1'b1;

        // 8*4 + 8*(-3) with unit weights
        load_w(0, 16, 1, 1, 0);
        run(0, 16, 16, 1, 0, 1'b0, 1'b0);
        check("c1_busy1",   busy_first, 1);
        check("c1_wr_n",    wr_n,       1);
        check("c1_wr_addr", wr_a[0],    16);
        check("c1_wr_data", wr_d[0],    8);
        check("c1_wr_cyc",  wr_c[0],    19);
        check("c1_done",    done_cyc,   20);
        check("c1_busy_dn", busy_at_done, 0);

        load_w(0, 16, 1, -1, 0);
        run(0, 16, 16, 1, 0, 1'b1, 1'b0);
        check("c2_relu_data", wr_d[0], 0);
        check("c2_relu_n",    wr_n,    1);
        run(0, 16, 16, 1, 0, 1'b0, 1'b0);
        check("c2_neg_data",  wr_d[0], -8);

        load_w(0, 8, 1, 10000, 0);
        run(0, 8, 16, 1, 0, 1'b0, 1'b0);
        check("c3_sat_pos",   wr_d[0],  32767);
        check("c3_wr_cyc",    wr_c[0],  11);
        check("c3_done",      done_cyc, 12);
        load_w(0, 8, 1, -10000, 0);
        run(0, 8, 16, 1, 0, 1'b1, 1'b0);
        check("c3_relu_neg",  wr_d[0],  0);
        run(0, 8, 16, 1, 0, 1'b0, 1'b0);
        check("c3_sat_neg",   wr_d[0],  -32768);

        run(0, 0, 16, 1, 0, 1'b0, 1'b0);
        check("c4_inz_done", done_cyc, 1);
        check("c4_inz_busy", busy_hi,  0);
        check("c4_inz_wr",   wr_n,     0);
        run(0, 16, 16, 0, 0, 1'b0, 1'b0);
        check("c4_outz_done", done_cyc, 1);
        check("c4_outz_busy", busy_hi,  0);
        check("c4_outz_wr",   wr_n,     0);

        // inputs -3 x8, bias j+1, output range wraps past 4095
        load_w(100, 8, 3, 1, 1);
        run(8, 8, 4095, 3, 100, 1'b0, 1'b1);
        check("c5_wr_n",  wr_n,    3);
        check("c5_a0",    wr_a[0], 4095);
        check("c5_a1",    wr_a[1], 0);
        check("c5_a2",    wr_a[2], 1);
        check("c5_d0",    wr_d[0], -23);
        check("c5_d1",    wr_d[1], -22);
        check("c5_d2",    wr_d[2], -21);
        check("c5_c2",    wr_c[2], 33);
        check("c5_done",  done_cyc, 34);

        // abort mid-READ
        load_w(0, 16, 1, 1, 0);
        repeat (2) @(negedge clk);
        in_base = 12'd0; in_count = 12'd16; out_base = 12'd16; out_count = 12'd1;
        w_base = 16'd0; relu_en = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("c6_busy_pre", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("c6_busy",    int'(busy),    0);
        check("c6_rd_addr", int'(rd_addr), 0);
        check("c6_w_addr",  int'(w_addr),  0);
        check("c6_wr_en",   int'(wr_en),   0);
        check("c6_wr_addr", int'(wr_addr), 0);
        check("c6_wr_data", int'(wr_data), 0);
        rst_wr = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (wr_en || done) rst_wr++;
        end
        check("c6_no_wr", rst_wr, 0);
        reset_n = 1'b1;
        run(0, 16, 16, 1, 0, 1'b0, 1'b0);
        check("c6_wr_data2", wr_d[0],  8);
        check("c6_wr_cyc2",  wr_c[0],  19);
        check("c6_done2",    done_cyc, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
